// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait, branch flush
// and load-use hazards into one set of register enables, plus saturating stall counters.
//
// state    | meaning
// RUN      | normal issue; branch flush or load-use bubble decoded combinationally
// MEM_WAIT | whole pipeline frozen until data memory acks or the wait times out
module pipeline_stall_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RegisterRt_i,
  input  logic [31:0]      IFID_instr_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IDEXWrite_o,
  output logic             EXMEMWrite_o,
  output logic             IDEXBubble_o,
  output logic             IFIDFlush_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] lu_stall_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_set;
  logic [4:0] ifid_rs, ifid_rt;
  logic       lu;
  logic       unused_instr_bits;

  assign ifid_rs = IFID_instr_i[25:21];
  assign ifid_rt = IFID_instr_i[20:16];
  assign unused_instr_bits = ^{IFID_instr_i[31:26], IFID_instr_i[15:0]};

  assign lu = IDEX_MemRead_i && (IDEX_RegisterRt_i != 5'd0) &&
              ((IDEX_RegisterRt_i == ifid_rs) || (IDEX_RegisterRt_i == ifid_rt));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_set  = 1'b0;
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IDEXWrite_o  = 1'b1;
    EXMEMWrite_o = 1'b1;
    IDEXBubble_o = 1'b0;
    IFIDFlush_o  = 1'b0;
    // Outputs are forced to idle RUN decode while reset is held.
    if (rst_i) begin
      case (state_q)
        RUN: begin
          if (mem_req_i && !mem_ack_i) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXWrite_o  = 1'b0;
            EXMEMWrite_o = 1'b0;
            state_d      = MEM_WAIT;
            wait_d       = 8'd1;
          end else if (branch_taken_i) begin
            IFIDFlush_o = 1'b1;
          end else if (lu) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          PCWrite_o    = 1'b0;
          IFIDWrite_o  = 1'b0;
          IDEXWrite_o  = 1'b0;
          EXMEMWrite_o = 1'b0;
          if (mem_ack_i) begin
            state_d = RUN;
            wait_d  = 8'd0;
          end else if (wait_q == WAIT_LAST) begin
            timeout_set = 1'b1;
            state_d     = RUN;
            wait_d      = 8'd0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      timeout_o       <= 1'b0;
      lu_stall_cnt_o  <= '0;
      mem_stall_cnt_o <= '0;
    end else begin
      if (timeout_set) timeout_o <= 1'b1;
      if (IDEXBubble_o && (lu_stall_cnt_o != '1))
        lu_stall_cnt_o <= lu_stall_cnt_o + CNT_W'(1);
      if (!EXMEMWrite_o && (mem_stall_cnt_o != '1))
        mem_stall_cnt_o <= mem_stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a default instance plus a CNT_W=2,
// MEM_TIMEOUT=4 instance sharing the same stimulus.
module tb_pipeline_stall_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RegisterRt_i;
  logic [31:0] IFID_instr_i;
  logic        branch_taken_i, mem_req_i, mem_ack_i;

  logic        pc1, ifid1, idex1, exmem1, bub1, fl1, to1;
  logic [15:0] lu1, mem1;
  logic        pc2, ifid2, idex2, exmem2, bub2, fl2, to2;
  logic [1:0]  lu2, mem2;
  logic [5:0]  ctl1, ctl2;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ADD_R8_R9 = 32'h0109_5020;
  localparam logic [5:0]  C_IDLE  = 6'b111100;
  localparam logic [5:0]  C_FRZ   = 6'b000000;
  localparam logic [5:0]  C_LU    = 6'b001110;
  localparam logic [5:0]  C_FLUSH = 6'b111101;

  assign ctl1 = {pc1, ifid1, idex1, exmem1, bub1, fl1};
  assign ctl2 = {pc2, ifid2, idex2, exmem2, bub2, fl2};

  always #5 clk_i = ~clk_i;

  pipeline_stall_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .IDEX_MemRead_i(IDEX_MemRead_i),
    .IDEX_RegisterRt_i(IDEX_RegisterRt_i), .IFID_instr_i(IFID_instr_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .PCWrite_o(pc1), .IFIDWrite_o(ifid1), .IDEXWrite_o(idex1), .EXMEMWrite_o(exmem1),
    .IDEXBubble_o(bub1), .IFIDFlush_o(fl1), .timeout_o(to1),
    .lu_stall_cnt_o(lu1), .mem_stall_cnt_o(mem1)
  );

  pipeline_stall_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .IDEX_MemRead_i(IDEX_MemRead_i),
    .IDEX_RegisterRt_i(IDEX_RegisterRt_i), .IFID_instr_i(IFID_instr_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .PCWrite_o(pc2), .IFIDWrite_o(ifid2), .IDEXWrite_o(idex2), .EXMEMWrite_o(exmem2),
    .IDEXBubble_o(bub2), .IFIDFlush_o(fl2), .timeout_o(to2),
    .lu_stall_cnt_o(lu2), .mem_stall_cnt_o(mem2)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    IDEX_MemRead_i    = 1'b0;
    IDEX_RegisterRt_i = 5'd0;
    IFID_instr_i      = 32'd0;
    branch_taken_i    = 1'b0;
    mem_req_i         = 1'b0;
    mem_ack_i         = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b0;
    // hazard inputs active during reset must not leak to the outputs
    IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd8; IFID_instr_i = ADD_R8_R9;
    branch_taken_i = 1'b1; mem_req_i = 1'b1;
    tick(); tick(); tick();
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_IDLE) begin failures++; $display("FAIL reset_ctl got %b want %b", ctl1, C_IDLE); end
    checks++;
    if (lu1 !== 16'd0 || mem1 !== 16'd0 || to1 !== 1'b0) begin
      failures++; $display("FAIL reset_state got lu=%0d mem=%0d to=%b want 0 0 0", lu1, mem1, to1);
    end
    clear_inputs();
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_IDLE) begin failures++; $display("FAIL post_reset_ctl got %b want %b", ctl1, C_IDLE); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd8; IFID_instr_i = ADD_R8_R9;
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_LU) begin failures++; $display("FAIL lu_stall_ctl got %b want %b", ctl1, C_LU); end
    tick();
    IDEX_MemRead_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_IDLE) begin failures++; $display("FAIL lu_after_bubble got %b want %b", ctl1, C_IDLE); end
    checks++;
    if (lu1 !== 16'd1) begin failures++; $display("FAIL lu_cnt_one got %0d want 1", lu1); end
    tick();
    IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd0; IFID_instr_i = 32'h0000_0020;
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_IDLE) begin failures++; $display("FAIL lu_reg0 got %b want %b", ctl1, C_IDLE); end
    tick();
    IDEX_RegisterRt_i = 5'd9; IFID_instr_i = ADD_R8_R9;
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_LU) begin failures++; $display("FAIL lu_rt_match got %b want %b", ctl1, C_LU); end
    tick();
    clear_inputs();
    checks++;
    if (lu1 !== 16'd2) begin failures++; $display("FAIL lu_cnt_two got %0d want 2", lu1); end
  endtask

  task automatic test_branch_vs_lu();
    do_reset();
    IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd8; IFID_instr_i = ADD_R8_R9;
    branch_taken_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_FLUSH) begin failures++; $display("FAIL branch_over_lu got %b want %b", ctl1, C_FLUSH); end
    tick();
    clear_inputs();
    checks++;
    if (lu1 !== 16'd0) begin failures++; $display("FAIL branch_lu_cnt got %0d want 0", lu1); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req_i = 1'b1; mem_ack_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_IDLE) begin failures++; $display("FAIL mem_single_cycle got %b want %b", ctl1, C_IDLE); end
    tick();
    mem_ack_i = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) branch_taken_i = 1'b1;
      if (c == 4) mem_ack_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (ctl1 !== C_FRZ) begin failures++; $display("FAIL mem_freeze_c%0d got %b want %b", c, ctl1, C_FRZ); end
      tick();
      mem_req_i = 1'b0; branch_taken_i = 1'b0;
    end
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_IDLE) begin failures++; $display("FAIL mem_resume got %b want %b", ctl1, C_IDLE); end
    checks++;
    if (mem1 !== 16'd5) begin failures++; $display("FAIL mem_stall_cnt got %0d want 5", mem1); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_i = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (ctl2 !== C_FRZ || to2 !== 1'b0) begin
        failures++; $display("FAIL to_freeze_c%0d got ctl=%b to=%b want %b 0", c, ctl2, to2, C_FRZ);
      end
      tick();
      mem_req_i = 1'b0;
    end
    @(negedge clk_i);
    checks++;
    if (ctl2 !== C_IDLE || to2 !== 1'b1) begin
      failures++; $display("FAIL to_exit got ctl=%b to=%b want %b 1", ctl2, to2, C_IDLE);
    end
    checks++;
    if (mem2 !== 2'd3) begin failures++; $display("FAIL to_mem_cnt_sat got %0d want 3", mem2); end
    tick(); tick(); tick();
    checks++;
    if (to2 !== 1'b1 || to1 !== 1'b0) begin
      failures++; $display("FAIL to_sticky got to2=%b to1=%b want 1 0", to2, to1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      IDEX_MemRead_i = 1'b1; IDEX_RegisterRt_i = 5'd8; IFID_instr_i = ADD_R8_R9;
      tick();
      IDEX_MemRead_i = 1'b0;
      tick();
    end
    checks++;
    if (lu2 !== 2'd3) begin failures++; $display("FAIL lu_sat got %0d want 3", lu2); end
    checks++;
    if (lu1 !== 16'd5) begin failures++; $display("FAIL lu_five got %0d want 5", lu1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_req_i = 1'b1;
    tick();
    mem_req_i = 1'b0;
    tick(); tick(); tick(); tick();
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_FRZ || to2 !== 1'b1 || mem1 !== 16'd5) begin
      failures++; $display("FAIL ar_pre got ctl=%b to2=%b mem=%0d want %b 1 5", ctl1, to2, mem1, C_FRZ);
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (ctl1 !== C_IDLE) begin failures++; $display("FAIL ar_ctl got %b want %b", ctl1, C_IDLE); end
    checks++;
    if (mem1 !== 16'd0 || to2 !== 1'b0 || mem2 !== 2'd0) begin
      failures++; $display("FAIL ar_clear got mem1=%0d to2=%b mem2=%0d want 0 0 0", mem1, to2, mem2);
    end
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl1 !== C_IDLE) begin failures++; $display("FAIL ar_run got %b want %b", ctl1, C_IDLE); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_lu();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
